// File: rtl/pe_mac_tile.sv
// pe_mac_tile: pipelined signed fixed-point matrix-vector MAC tile.
// Computes N_OUT dot products of an N_IN-element data beat against an
// N_OUT x N_IN weight matrix, accumulates across first/last framed tiles,
// then rounds, saturates and hands results downstream over valid/ready.
// Pipeline: S1 products -> S2 row sums -> S3 accumulator -> output register.
// A single advance signal freezes every stage, so backpressure and clock
// enable never drop or duplicate a beat.
module pe_mac_tile #(
  parameter int WIDTH     = 16,
  parameter int N_IN      = 8,
  parameter int N_OUT     = 4,
  parameter int FRAC      = 8,
  parameter int ACC_GUARD = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [N_IN*WIDTH-1:0]         DATA,
  input  logic [N_OUT*N_IN*WIDTH-1:0]   WEIGHT,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_OUT*WIDTH-1:0]        Q,
  output logic [N_OUT-1:0]              Q_SAT,
  output logic                          sat_sticky
);

  localparam int LG    = $clog2(N_IN);
  localparam int PW    = 2 * WIDTH;
  localparam int SW    = PW + LG;
  localparam int ACC_W = SW + ACC_GUARD;
  localparam int RW    = ACC_W + 1;
  localparam int NP    = N_OUT * N_IN;

  // One extra bit on the rounding path so adding the half-LSB never wraps.
  localparam logic signed [RW-1:0] HALF = RW'(1) <<< (FRAC - 1);
  localparam logic signed [RW-1:0] QMAX = (RW'(1) <<< (WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] QMIN = ~QMAX;

  logic stall;
  logic advance;
  logic accept;

  logic signed [PW-1:0]    prod_c  [NP];
  logic signed [PW-1:0]    s1_prod [NP];
  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;

  logic signed [SW-1:0]    sum_c   [N_OUT];
  logic signed [SW-1:0]    s2_sum  [N_OUT];
  logic                    s2_valid;
  logic                    s2_first;
  logic                    s2_last;

  logic signed [ACC_W-1:0] acc_base [N_OUT];
  logic signed [ACC_W-1:0] acc_new  [N_OUT];
  logic signed [ACC_W-1:0] acc      [N_OUT];
  logic                    s3_valid;
  logic                    s3_last;

  logic signed [RW-1:0]    r_c [N_OUT];
  logic [N_OUT*WIDTH-1:0]  q_c;
  logic [N_OUT-1:0]        sat_c;

  // The whole pipeline moves together; in_ready depends only on ce and the
  // output register so it never combinationally loops through in_valid.
  assign stall    = out_valid & ~out_ready;
  assign advance  = ce & ~stall;
  assign in_ready = advance;
  assign accept   = in_valid & advance;

  // Full-precision signed products of every weight with its data element.
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      prod_c[k] = PW'($signed(DATA[(k % N_IN)*WIDTH +: WIDTH])) *
                  PW'($signed(WEIGHT[k*WIDTH +: WIDTH]));
    end
  end

  // S1: capture products and framing on accept; a bubble just clears valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < NP; k++) s1_prod[k] <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        for (int k = 0; k < NP; k++) s1_prod[k] <= prod_c[k];
      end
    end
  end

  // Per-row adder tree, widened by clog2(N_IN) so the sum cannot overflow.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      sum_c[j] = '0;
      for (int i = 0; i < N_IN; i++) begin
        sum_c[j] = sum_c[j] + SW'(s1_prod[j*N_IN + i]);
      end
    end
  end

  // S2: register the row sums together with the framing bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      for (int j = 0; j < N_OUT; j++) s2_sum[j] <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first <= s1_first;
        s2_last  <= s1_last;
        for (int j = 0; j < N_OUT; j++) s2_sum[j] <= sum_c[j];
      end
    end
  end

  // Accumulator update: a first beat restarts from zero, otherwise the tile
  // sum is added to the running value with plain wrap-around.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      acc_base[j] = s2_first ? '0 : acc[j];
      acc_new[j]  = acc_base[j] + ACC_W'(s2_sum[j]);
    end
  end

  // S3: commit the accumulator and remember whether this beat closes a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else if (advance) begin
      s3_valid <= s2_valid;
      s3_last  <= s2_valid & s2_last;
      if (s2_valid) begin
        for (int j = 0; j < N_OUT; j++) acc[j] <= acc_new[j];
      end
    end
  end

  // Round half toward +inf, drop the fraction, then clamp into WIDTH bits.
  always_comb begin
    q_c   = '0;
    sat_c = '0;
    for (int j = 0; j < N_OUT; j++) begin
      r_c[j] = (RW'(acc[j]) + HALF) >>> FRAC;
      if (r_c[j] > QMAX) begin
        q_c[j*WIDTH +: WIDTH] = QMAX[WIDTH-1:0];
        sat_c[j]              = 1'b1;
      end else if (r_c[j] < QMIN) begin
        q_c[j*WIDTH +: WIDTH] = QMIN[WIDTH-1:0];
        sat_c[j]              = 1'b1;
      end else begin
        q_c[j*WIDTH +: WIDTH] = r_c[j][WIDTH-1:0];
      end
    end
  end

  // Output register: a closing beat loads a new result (even while the old
  // one is being taken), otherwise a completed handshake empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      Q          <= '0;
      Q_SAT      <= '0;
      sat_sticky <= 1'b0;
    end else if (advance) begin
      if (s3_valid && s3_last) begin
        out_valid  <= 1'b1;
        Q          <= q_c;
        Q_SAT      <= sat_c;
        sat_sticky <= sat_sticky | (|sat_c);
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_tile.sv
// tb_pe_mac_tile: table-driven and scoreboard checks for pe_mac_tile.
module tb_pe_mac_tile;

  localparam int W  = 16;
  localparam int NI = 8;
  localparam int NO = 4;
  localparam int FR = 8;

  typedef struct {
    logic [NI*W-1:0]    data;
    logic [NO*NI*W-1:0] weight;
    logic               first;
    logic               last;
    logic [NO*W-1:0]    expQ;
    logic [NO-1:0]      expSat;
  } vec_t;

  typedef struct {
    logic [NO*W-1:0] q;
    logic [NO-1:0]   sat;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic               in_first;
  logic               in_last;
  logic [NI*W-1:0]    DATA;
  logic [NO*NI*W-1:0] WEIGHT;
  logic               out_valid;
  logic               out_ready;
  logic [NO*W-1:0]    Q;
  logic [NO-1:0]      Q_SAT;
  logic               sat_sticky;

  exp_t   sbQueue[$];
  vec_t   table_v[6];
  longint modelAcc[NO];
  int     vecCount = 0;
  int     errCount = 0;
  int     popCount = 0;
  int     bpCycle  = 0;
  logic   bpMode   = 1'b0;

  pe_mac_tile #(.WIDTH(W), .N_IN(NI), .N_OUT(NO), .FRAC(FR), .ACC_GUARD(8)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .DATA(DATA), .WEIGHT(WEIGHT),
    .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .Q_SAT(Q_SAT), .sat_sticky(sat_sticky)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ready and clock enable; patterned only in backpressure mode
  initial begin
    out_ready = 1'b1;
    ce        = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bpMode) begin
        bpCycle++;
        out_ready = (bpCycle % 3 == 0);
        ce        = !(bpCycle == 4 || bpCycle == 5);
      end else begin
        out_ready = 1'b1;
        ce        = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [NI*W-1:0] fillData(input logic [W-1:0] v);
    logic [NI*W-1:0] d;
    for (int i = 0; i < NI; i++) d[i*W +: W] = v;
    return d;
  endfunction

  function automatic logic [NO*NI*W-1:0] fillRows(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                                   input logic [W-1:0] w2, input logic [W-1:0] w3);
    logic [NO*NI*W-1:0] w;
    logic [W-1:0]       rv [NO];
    rv[0] = w0; rv[1] = w1; rv[2] = w2; rv[3] = w3;
    for (int j = 0; j < NO; j++)
      for (int i = 0; i < NI; i++) w[(j*NI+i)*W +: W] = rv[j];
    return w;
  endfunction

  // Reference model: 64-bit integer dot products, accumulate, round, clamp
  task automatic modelBeat(input logic [NI*W-1:0] d, input logic [NO*NI*W-1:0] w, input logic first,
                           output logic [NO*W-1:0] q, output logic [NO-1:0] sat);
    longint s;
    longint r;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    q   = '0;
    sat = '0;
    for (int j = 0; j < NO; j++) begin
      s = 0;
      for (int i = 0; i < NI; i++) begin
        a = d[i*W +: W];
        b = w[(j*NI+i)*W +: W];
        s = s + longint'(a) * longint'(b);
      end
      modelAcc[j] = (first ? 64'sd0 : modelAcc[j]) + s;
      r = (modelAcc[j] + (64'sd1 <<< (FR-1))) >>> FR;
      if (r > 32767) begin
        q[j*W +: W] = 16'h7FFF; sat[j] = 1'b1;
      end else if (r < -32768) begin
        q[j*W +: W] = 16'h8000; sat[j] = 1'b1;
      end else begin
        q[j*W +: W] = 16'(r);
      end
    end
  endtask

  // Drive one beat, hold it until accepted, and queue its expected result
  task automatic applyStimulus(input logic [NI*W-1:0] d, input logic [NO*NI*W-1:0] w,
                               input logic first, input logic last,
                               input logic [NO*W-1:0] expQ, input logic [NO-1:0] expSat);
    int   waitCycles;
    exp_t e;
    waitCycles = 0;
    DATA     = d;
    WEIGHT   = w;
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      waitCycles++;
    end while (!in_ready && waitCycles < 200);
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    end else if (last) begin
      e.q   = expQ;
      e.sat = expSat;
      sbQueue.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sbQueue.size() != 0) checkOutput("drain_timeout", 64'(sbQueue.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: any valid Q must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        checkOutput("q", 64'(Q), 64'(sbQueue[0].q));
        checkOutput("q_sat", 64'(Q_SAT), 64'(sbQueue[0].sat));
        if (out_ready && ce) begin
          void'(sbQueue.pop_front());
          popCount++;
        end
      end
    end
    if (!rst && (!ce || (out_valid && !out_ready)))
      checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
  end

  initial begin
    logic [NI*W-1:0]    rd;
    logic [NO*NI*W-1:0] rw;
    logic [NO*W-1:0]    mq;
    logic [NO-1:0]      ms;
    logic               sawOut;
    int                 popBase;

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    DATA = '0; WEIGHT = '0;
    for (int j = 0; j < NO; j++) modelAcc[j] = 0;

    table_v[0] = '{fillData(16'h0100), fillRows(16'h0040, 16'h0080, 16'h00C0, 16'h0100), 1'b1, 1'b1,
                   64'h0800_0600_0400_0200, 4'h0};
    table_v[1] = '{fillData(16'h0100), fillRows(16'h0040, 16'h0080, 16'h00C0, 16'h0100), 1'b1, 1'b0,
                   64'h0, 4'h0};
    table_v[2] = '{fillData(16'h0100), fillRows(16'h0040, 16'h0080, 16'h00C0, 16'h0100), 1'b0, 1'b1,
                   64'h1000_0C00_0800_0400, 4'h0};
    table_v[3] = '{fillData(16'h7B2A), fillRows(16'h8F04, 16'h8F04, 16'h8F04, 16'h8F04), 1'b1, 1'b1,
                   64'h8000_8000_8000_8000, 4'hF};
    table_v[4] = '{128'h1, 512'h0080, 1'b1, 1'b1, 64'h0000_0000_0000_0001, 4'h0};
    table_v[5] = '{128'h1, 512'hFF80, 1'b1, 1'b1, 64'h0, 4'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_q", 64'(Q), 64'd0);
    checkOutput("rst_q_sat", 64'(Q_SAT), 64'd0);
    checkOutput("rst_sticky", 64'(sat_sticky), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: result visible after the third edge following acceptance
    applyStimulus(table_v[0].data, table_v[0].weight, 1'b1, 1'b1, table_v[0].expQ, table_v[0].expSat);
    checkOutput("lat_t0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("lat_t1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("lat_t2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("lat_t3", 64'(out_valid), 64'd1);
    waitDrain();

    // A first-only beat primes the accumulator without producing output
    applyStimulus(table_v[1].data, table_v[1].weight, 1'b1, 1'b0, '0, '0);
    sawOut = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) sawOut = 1'b1;
    end
    checkOutput("first_only_no_out", 64'(sawOut), 64'd0);
    applyStimulus(table_v[2].data, table_v[2].weight, 1'b0, 1'b1, table_v[2].expQ, table_v[2].expSat);
    waitDrain();

    // Table vectors streamed back to back
    for (int v = 0; v < 6; v++)
      applyStimulus(table_v[v].data, table_v[v].weight, table_v[v].first, table_v[v].last,
                    table_v[v].expQ, table_v[v].expSat);
    waitDrain();
    checkOutput("sticky_after_sat", 64'(sat_sticky), 64'd1);

    // Backpressure and clock-enable gaps with model-checked random beats
    popBase = popCount;
    bpCycle = 0;
    bpMode  = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NI; i++)
        rd[i*W +: W] = (b == 3) ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
      for (int k = 0; k < NO*NI; k++)
        rw[k*W +: W] = (b == 3) ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
      modelBeat(rd, rw, 1'b1, mq, ms);
      applyStimulus(rd, rw, 1'b1, 1'b1, mq, ms);
    end
    waitDrain();
    bpMode = 1'b0;
    checkOutput("bp_beat_count", 64'(popCount - popBase), 64'd6);
    @(posedge clk); #1;

    // Asynchronous reset with beats in flight
    applyStimulus(table_v[3].data, table_v[3].weight, 1'b1, 1'b1, table_v[3].expQ, table_v[3].expSat);
    applyStimulus(table_v[0].data, table_v[0].weight, 1'b1, 1'b0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_q", 64'(Q), 64'd0);
    checkOutput("mid_rst_sticky", 64'(sat_sticky), 64'd0);
    sbQueue.delete();
    for (int j = 0; j < NO; j++) modelAcc[j] = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(table_v[0].data, table_v[0].weight, 1'b0, 1'b1, table_v[0].expQ, table_v[0].expSat);
    waitDrain();
    checkOutput("final_queue_empty", 64'(sbQueue.size()), 64'd0);
    checkOutput("final_sticky", 64'(sat_sticky), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
